seg_display_scan: RTL

Time-multiplexed driver for the board's common-anode seven-segment display: the output-side counterpart of the button filtering on the input side of the lab designs. It holds a DIGITS-wide hex value, cycles one digit slot every DIV clocks, drives anode and segment lines with anti-ghosting blanking, and takes new values through a load strobe. New values are applied only at frame boundaries, so a displayed number never tears.

---
 rtl/seg_display_scan_pkg.sv | 12 +
 rtl/seg_display_scan_if.sv | 13 +
 rtl/seg_display_scan_hex_to_seg.sv | 9 +
 rtl/seg_display_scan.sv | 78 +++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
// seg_pkg: seven-segment font and bit order shared by the display scanner.
package seg_pkg;
  // Segment bit order is {g,f,e,d,c,b,a}; segments[0] = a. Codes are active-high.
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [16*7-1:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] hexFont(input logic [3:0] n);
    return FONT[n*7 +: 7];
  endfunction
endpackage

// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if: load-side value bus and scanned display outputs.
interface seg_display_scan_if #(parameter int DIGITS = 4) ();
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dotMask;
  logic [DIGITS-1:0] blankMask;
  logic load;
  logic [DIGITS-1:0] anodes;
  logic [6:0] segments;
  logic dot;
  logic frameStart;
  modport master (output value, dotMask, blankMask, load, input anodes, segments, dot, frameStart);
  modport slave (input value, dotMask, blankMask, load, output anodes, segments, dot, frameStart);
endinterface

// File: rtl/seg_display_scan_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-high seven-segment code.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);
  assign segs = hexFont(nibble);
endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexed seven-segment driver with frame-aligned value updates.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV = 10000,
  parameter int BLANK = 16,
  parameter bit ACTIVE_LOW = 1
) (
  input logic clockSource,
  input logic reset,
  seg_display_scan_if.slave bus
);
  localparam int SW = $clog2(DIV);
  localparam int DW = $clog2(DIGITS);
  logic [SW-1:0] slotCnt;
  logic [DW-1:0] digitIdx;
  logic [4*DIGITS-1:0] pendValue, actValue;
  logic [DIGITS-1:0] pendDot, pendBlank, actDot, actBlank;
  logic slotEnd, boundary, blanking, dotRaw;
  logic [3:0] nibble;
  logic [6:0] font, segRaw;
  logic [DIGITS-1:0] anodeRaw;
  assign slotEnd = slotCnt == SW'(DIV - 1);
  assign boundary = slotEnd && digitIdx == DW'(DIGITS - 1);
  assign blanking = slotCnt < SW'(BLANK);
  assign nibble = actValue[4*digitIdx +: 4];
  hex_to_seg u_font (.nibble(nibble), .segs(font));
  always_comb begin
    anodeRaw = blanking ? '0 : DIGITS'(1) << digitIdx;
    segRaw = (blanking || actBlank[digitIdx]) ? SEG_OFF : font;
    dotRaw = !blanking && !actBlank[digitIdx] && actDot[digitIdx];
  end
  always_ff @(posedge clockSource) begin
    if (reset) begin
      slotCnt <= '0;
      digitIdx <= '0;
    end else begin
      slotCnt <= slotEnd ? '0 : slotCnt + 1'b1;
      if (slotEnd) digitIdx <= digitIdx == DW'(DIGITS - 1) ? '0 : digitIdx + 1'b1;
    end
  end
  // A load coinciding with the boundary bypasses pending so it still lands in the next frame.
  always_ff @(posedge clockSource) begin
    if (reset) begin
      pendValue <= '0;
      pendDot <= '0;
      pendBlank <= '0;
      actValue <= '0;
      actDot <= '0;
      actBlank <= '0;
    end else begin
      if (bus.load) begin
        pendValue <= bus.value;
        pendDot <= bus.dotMask;
        pendBlank <= bus.blankMask;
      end
      if (boundary) begin
        actValue <= bus.load ? bus.value : pendValue;
        actDot <= bus.load ? bus.dotMask : pendDot;
        actBlank <= bus.load ? bus.blankMask : pendBlank;
      end
    end
  end
  always_ff @(posedge clockSource) begin
    if (reset) begin
      bus.anodes <= {DIGITS{ACTIVE_LOW}};
      bus.segments <= {7{ACTIVE_LOW}};
      bus.dot <= ACTIVE_LOW;
      bus.frameStart <= 1'b0;
    end else begin
      bus.anodes <= anodeRaw ^ {DIGITS{ACTIVE_LOW}};
      bus.segments <= segRaw ^ {7{ACTIVE_LOW}};
      bus.dot <= dotRaw ^ ACTIVE_LOW;
      bus.frameStart <= slotCnt == '0 && digitIdx == '0;
    end
  end
endmodule
